pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Controller that decides every PC update in the five-stage pipeline. It drives the write enable and next-value inputs of the `PC` register and sequences reset-vector and interrupt-vector loads from instruction memory. It also arbitrates between sequential fetch, branch/jump redirects, stalls, halt and interrupt entry. It sits in the fetch stage, between the `PC` register, instruction memory and the hazard/execute logic.

## Interface
- `ADDR_W`, 32, PC and address width
- `RESET_VEC_ADDR`, 0, imem word holding the reset entry PC
- `INT_VEC_ADDR`, 1, imem word holding the interrupt handler PC
- `STEP`, 1, sequential PC increment
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `pc_cur` in ADDR_W: current `PC` register output
- `stall` in 1: hazard unit freezes fetch
- `redirect_valid` in 1: taken branch/jump/return from execute
- `redirect_target` in ADDR_W: redirect destination
- `int_req` in 1: level interrupt request
- `pipe_drained` in 1: no valid instruction past fetch
- `hlt_req` in 1: HLT decoded
- `imem_rdata` in 32: instruction memory data, fixed 1-cycle read latency
- `pc_we` out 1: `PC` write enable
- `pc_next` out ADDR_W: `PC` write data
- `vec_rd` out 1: sequencer owns the imem port this cycle
- `vec_addr` out ADDR_W: imem address while `vec_rd`=1
- `fetch_valid` out 1: fetch stage may issue instruction at `pc_cur`
- `int_ack` out 1: one-cycle pulse on handler entry
- `int_ret_pc` out ADDR_W: saved return PC, registered
- `halted` out 1: core halted

## Operation
- States: RST_REQ, RST_LOAD, RUN, INT_DRAIN, INT_REQ, INT_LOAD, HALT.
- Reset (`rst`=0, asynchronous): state RST_REQ. `int_ret_pc`=0, `int_ack`=0, `halted`=0. `pc_we`=0, `fetch_valid`=0.
- RST_REQ: `vec_rd`=1, `vec_addr`=RESET_VEC_ADDR. Go to RST_LOAD.
- RST_LOAD: `pc_we`=1, `pc_next`=`imem_rdata`. Go to RUN.
- RUN: `fetch_valid`=!`stall`. Priority, highest first:
  1. `redirect_valid`: `pc_we`=1, `pc_next`=`redirect_target`. Applies even when `stall`=1.
  2. `hlt_req`: `pc_we`=0. Go to HALT.
  3. `int_req`: `pc_we`=0, `int_ret_pc`<=`pc_cur`. Go to INT_DRAIN.
  4. `stall`: `pc_we`=0.
  5. Otherwise: `pc_we`=1, `pc_next`=`pc_cur`+STEP.
- Arithmetic is modulo 2^ADDR_W: 0xFFFFFFFF+1 wraps to 0. No flag is raised.
- INT_DRAIN: `fetch_valid`=0, `pc_we`=0.
  - `redirect_valid` in this state: `int_ret_pc`<=`redirect_target`, because an in-flight branch wins the return address.
  - Go to INT_REQ when `pipe_drained`=1 and `redirect_valid`=0.
- INT_REQ: `vec_rd`=1, `vec_addr`=INT_VEC_ADDR. Go to INT_LOAD.
- INT_LOAD: `pc_we`=1, `pc_next`=`imem_rdata`, `int_ack`=1. Go to RUN.
- HALT: `halted`=1, `fetch_valid`=0, `pc_we`=0. `int_req` goes to INT_DRAIN with `int_ret_pc`<=`pc_cur`; `halted` clears on that exit. Only `rst` or `int_req` leaves HALT.
- `int_req` is ignored outside RUN and HALT. No nesting: the handler must deassert the source before the next RUN sample.

## Timing
- The state register, `int_ret_pc` and `int_ack` are flops.
- `pc_we`, `pc_next`, `fetch_valid`, `vec_rd` and `vec_addr` are combinational from state and inputs. The `PC` register captures them on the same edge.
- Reset to first valid fetch: RST_REQ at edge 1, RST_LOAD at edge 2. The PC holds the entry value after edge 2, and `fetch_valid`=1 in the cycle after that.
- Interrupt latency from RUN sampling `int_req`: drain cycles plus 3 edges until handler PC is in `PC`. The minimum is 1 drain cycle.
- `int_ack` is high for exactly the INT_LOAD cycle.
- Reset asserted mid-sequence (any state) returns to RST_REQ immediately. A partial vector load is discarded.
- In RUN, `vec_rd`=0 and `vec_addr`=0.

## Structure
- The shared package `pipe_pkg` holds:
  - the state enum,
  - default vector addresses,
  - `ADDR_W`.
- No sub-module: one FSM plus a combinational next-PC mux. The block instantiates nothing and connects to the existing `PC` at top level.

## Test plan
- Reset entry: imem[0]=0x100, release `rst` → `vec_rd` and `vec_addr`=0 for one cycle, PC=0x100 after 2 edges, then sequential fetch 0x101, 0x102.
- Stall with redirect: `stall`=1 for 3 cycles → PC holds. `redirect_valid`=1 with target 0x40 while stalled → PC=0x40 on the next edge.
- Interrupt: imem[1]=0x200, `int_req` at PC=0x105, `pipe_drained` after 2 cycles → `int_ret_pc`=0x105, `int_ack` one pulse, PC=0x200.
- Redirect during drain: `redirect_valid` with 0x300 in INT_DRAIN → `int_ret_pc`=0x300, then the handler is entered.
- Halt and wake: `hlt_req` → `halted`=1 and PC frozen for 10 cycles. `int_req` → `halted`=0, handler at 0x200.
- Wrap and mid-reset: PC=0xFFFFFFFF → next PC=0. Assert `rst` during INT_REQ → outputs reset immediately, PC reloads imem[0].

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared fetch-stage definitions: sequencer state encoding, default vector
// locations in instruction memory and the architectural PC width.
package pipe_pkg;

  localparam int PIPE_ADDR_W        = 32;
  localparam int DEF_RESET_VEC_ADDR = 0;
  localparam int DEF_INT_VEC_ADDR   = 1;

  typedef enum logic [2:0] {
    RST_REQ,
    RST_LOAD,
    RUN,
    INT_DRAIN,
    INT_REQ,
    INT_LOAD,
    HALT
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// PC sequencer: owns every update of the PC register. Loads the reset and
// interrupt entry PCs from instruction memory vectors, and in normal running
// arbitrates redirect > halt > interrupt > stall > sequential increment.
module pc_sequencer
  import pipe_pkg::*;
#(
  parameter int                ADDR_W         = PIPE_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = ADDR_W'(DEF_RESET_VEC_ADDR),
  parameter logic [ADDR_W-1:0] INT_VEC_ADDR   = ADDR_W'(DEF_INT_VEC_ADDR),
  parameter logic [ADDR_W-1:0] STEP           = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              int_req,
  input  logic              pipe_drained,
  input  logic              hlt_req,
  input  logic [31:0]       imem_rdata,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_next,
  output logic              vec_rd,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              fetch_valid,
  output logic              int_ack,
  output logic [ADDR_W-1:0] int_ret_pc,
  output logic              halted
);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_int_ret_pc;
  logic              r_int_ack;
  logic              w_ret_we;
  logic [ADDR_W-1:0] w_ret_nxt;
  logic [ADDR_W-1:0] w_vec_pc;

  // Vector words are full imem words; only the PC-width part is meaningful.
  assign w_vec_pc = ADDR_W'(imem_rdata);

  // State register; any reset abandons a partial vector load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RST_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Saved return PC and the handler-entry pulse, high only while in INT_LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_int_ret_pc <= '0;
      r_int_ack    <= 1'b0;
    end else begin
      if (w_ret_we) begin
        r_int_ret_pc <= w_ret_nxt;
      end
      r_int_ack <= (w_state_nxt == INT_LOAD);
    end
  end

  // Next state, PC write controls and vector-read port ownership.
  always_comb begin
    w_state_nxt = r_state;
    pc_we       = 1'b0;
    pc_next     = pc_cur;
    vec_rd      = 1'b0;
    vec_addr    = '0;
    fetch_valid = 1'b0;
    w_ret_we    = 1'b0;
    w_ret_nxt   = pc_cur;
    case (r_state)
      RST_REQ: begin
        vec_rd      = 1'b1;
        vec_addr    = RESET_VEC_ADDR;
        w_state_nxt = RST_LOAD;
      end
      RST_LOAD: begin
        pc_we       = 1'b1;
        pc_next     = w_vec_pc;
        w_state_nxt = RUN;
      end
      RUN: begin
        fetch_valid = !stall;
        if (redirect_valid) begin
          // A resolved branch must land even while fetch is frozen.
          pc_we   = 1'b1;
          pc_next = redirect_target;
        end else if (hlt_req) begin
          w_state_nxt = HALT;
        end else if (int_req) begin
          w_ret_we    = 1'b1;
          w_ret_nxt   = pc_cur;
          w_state_nxt = INT_DRAIN;
        end else if (!stall) begin
          pc_we   = 1'b1;
          pc_next = pc_cur + STEP;
        end
      end
      INT_DRAIN: begin
        if (redirect_valid) begin
          // An older branch still in flight decides where the handler returns.
          w_ret_we  = 1'b1;
          w_ret_nxt = redirect_target;
        end else if (pipe_drained) begin
          w_state_nxt = INT_REQ;
        end
      end
      INT_REQ: begin
        vec_rd      = 1'b1;
        vec_addr    = INT_VEC_ADDR;
        w_state_nxt = INT_LOAD;
      end
      INT_LOAD: begin
        pc_we       = 1'b1;
        pc_next     = w_vec_pc;
        w_state_nxt = RUN;
      end
      HALT: begin
        if (int_req) begin
          w_ret_we    = 1'b1;
          w_ret_nxt   = pc_cur;
          w_state_nxt = INT_DRAIN;
        end
      end
      default: begin
        w_state_nxt = RST_REQ;
      end
    endcase
  end

  assign int_ack    = r_int_ack;
  assign int_ret_pc = r_int_ret_pc;
  assign halted     = (r_state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: owns the PC register and a 1-cycle-latency imem,
// runs a directed scenario and compares the DUT against a behavioural model
// on every falling edge, plus literal expectations at key points.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'd0;
  localparam logic [31:0] IV = 32'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_q;
  logic        stall, redirect_valid, int_req, pipe_drained, hlt_req;
  logic [31:0] redirect_target;
  logic [31:0] imem_rdata;
  logic        pc_we, vec_rd, fetch_valid, int_ack, halted;
  logic [31:0] pc_next, vec_addr, int_ret_pc;
  logic [31:0] mem [0:15];

  int n_chk  = 0;
  int n_fail = 0;

  pc_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .pc_cur          (pc_q),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .int_req         (int_req),
    .pipe_drained    (pipe_drained),
    .hlt_req         (hlt_req),
    .imem_rdata      (imem_rdata),
    .pc_we           (pc_we),
    .pc_next         (pc_next),
    .vec_rd          (vec_rd),
    .vec_addr        (vec_addr),
    .fetch_valid     (fetch_valid),
    .int_ack         (int_ack),
    .int_ret_pc      (int_ret_pc),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  // PC register fed by the sequencer
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= 32'h0;
    else if (pc_we) pc_q <= pc_next;
  end

  // imem with one cycle read latency; only vector reads matter here
  always @(posedge clk) begin
    imem_rdata <= vec_rd ? mem[vec_addr[3:0]] : 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model: boot phase, interrupt vector phase, drain and halt flags
  int          boot;
  int          ivec;
  bit          draining, m_halt, m_ack;
  logic [31:0] m_ret, m_pc;

  initial begin
    logic        e_we, e_vrd, e_fv;
    logic [31:0] e_next, e_vaddr;
    forever begin
      @(negedge clk);
      if (!rst) begin
        boot = 0; ivec = 0; draining = 0; m_halt = 0; m_ack = 0;
        m_ret = 32'h0; m_pc = 32'h0;
        chk("rst_pc_we", {31'b0, pc_we}, 32'h0);
        chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        chk("rst_int_ack", {31'b0, int_ack}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_int_ret_pc", int_ret_pc, 32'h0);
        chk("rst_pc", pc_q, 32'h0);
      end else begin
        e_we = 0; e_next = 32'h0; e_vrd = 0; e_vaddr = 32'h0; e_fv = 0;
        if (boot == 0) begin
          e_vrd = 1; e_vaddr = RV;
        end else if (boot == 1) begin
          e_we = 1; e_next = mem[RV[3:0]];
        end else if (ivec == 1) begin
          e_vrd = 1; e_vaddr = IV;
        end else if (ivec == 2) begin
          e_we = 1; e_next = mem[IV[3:0]];
        end else if (!draining && !m_halt) begin
          e_fv = !stall;
          if (redirect_valid) begin
            e_we = 1; e_next = redirect_target;
          end else if (!hlt_req && !int_req && !stall) begin
            e_we = 1; e_next = pc_q + 32'd1;
          end
        end
        chk("m_pc", pc_q, m_pc);
        chk("m_pc_we", {31'b0, pc_we}, {31'b0, e_we});
        if (e_we) chk("m_pc_next", pc_next, e_next);
        chk("m_vec_rd", {31'b0, vec_rd}, {31'b0, e_vrd});
        chk("m_vec_addr", vec_addr, e_vaddr);
        chk("m_fetch_valid", {31'b0, fetch_valid}, {31'b0, e_fv});
        chk("m_int_ack", {31'b0, int_ack}, {31'b0, m_ack});
        chk("m_int_ret_pc", int_ret_pc, m_ret);
        chk("m_halted", {31'b0, halted}, {31'b0, m_halt});
        if (e_we) m_pc = e_next;
        if (boot < 2) begin
          boot++;
        end else if (ivec == 1) begin
          ivec = 2;
        end else if (ivec == 2) begin
          ivec = 0;
        end else if (draining) begin
          if (redirect_valid) m_ret = redirect_target;
          else if (pipe_drained) begin draining = 0; ivec = 1; end
        end else if (m_halt) begin
          if (int_req) begin m_ret = pc_q; m_halt = 0; draining = 1; end
        end else if (!redirect_valid) begin
          if (hlt_req) m_halt = 1;
          else if (int_req) begin m_ret = pc_q; draining = 1; end
        end
        m_ack = (ivec == 2);
      end
    end
  end

  // Directed scenario with literal expectations
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h100;
    mem[1] = 32'h200;
    rst = 0; stall = 0; redirect_valid = 0; redirect_target = 0;
    int_req = 0; pipe_drained = 0; hlt_req = 0;

    // reset entry
    step(2);
    chk("reset_pc_we", {31'b0, pc_we}, 32'h0);
    chk("reset_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    rst = 1;
    #1;
    chk("boot_vec_rd", {31'b0, vec_rd}, 32'h1);
    chk("boot_vec_addr", vec_addr, 32'h0);
    step(2);
    chk("boot_pc", pc_q, 32'h100);
    chk("boot_fetch_valid", {31'b0, fetch_valid}, 32'h1);
    step(1);
    chk("seq_pc1", pc_q, 32'h101);
    step(1);
    chk("seq_pc2", pc_q, 32'h102);

    // stall, then redirect while stalled
    stall = 1;
    step(3);
    chk("stall_hold", pc_q, 32'h102);
    redirect_valid = 1; redirect_target = 32'h40;
    step(1);
    chk("stall_redirect", pc_q, 32'h40);
    stall = 0; redirect_target = 32'h105;
    step(1);
    redirect_valid = 0;
    chk("goto_105", pc_q, 32'h105);

    // interrupt with two drain cycles
    int_req = 1;
    step(1);
    int_req = 0;
    chk("int_ret_105", int_ret_pc, 32'h105);
    step(1);
    pipe_drained = 1;
    step(1);
    pipe_drained = 0;
    step(1);
    chk("int_ack_high", {31'b0, int_ack}, 32'h1);
    step(1);
    chk("int_handler_pc", pc_q, 32'h200);
    chk("int_ack_low", {31'b0, int_ack}, 32'h0);

    // redirect during drain overrides return PC
    int_req = 1;
    step(1);
    int_req = 0;
    redirect_valid = 1; redirect_target = 32'h300; pipe_drained = 1;
    step(1);
    redirect_valid = 0;
    chk("drain_ret_300", int_ret_pc, 32'h300);
    step(1);
    pipe_drained = 0;
    step(2);
    chk("drain_handler_pc", pc_q, 32'h200);

    // halt and wake by interrupt
    hlt_req = 1;
    step(1);
    hlt_req = 0;
    chk("halted_set", {31'b0, halted}, 32'h1);
    step(10);
    chk("halted_still", {31'b0, halted}, 32'h1);
    chk("halt_pc_frozen", pc_q, 32'h200);
    int_req = 1;
    step(1);
    int_req = 0;
    chk("halted_clear", {31'b0, halted}, 32'h0);
    chk("halt_ret", int_ret_pc, 32'h200);
    pipe_drained = 1;
    step(1);
    pipe_drained = 0;
    step(2);
    chk("wake_handler_pc", pc_q, 32'h200);

    // wrap at top of address space
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFF;
    step(1);
    redirect_valid = 0;
    chk("wrap_top", pc_q, 32'hFFFF_FFFF);
    step(1);
    chk("wrap_zero", pc_q, 32'h0);

    // reset asserted during the interrupt vector request
    int_req = 1;
    step(1);
    int_req = 0; pipe_drained = 1;
    step(1);
    pipe_drained = 0;
    chk("intreq_vec_rd", {31'b0, vec_rd}, 32'h1);
    chk("intreq_vec_addr", vec_addr, 32'h1);
    rst = 0;
    #1;
    chk("midrst_pc_we", {31'b0, pc_we}, 32'h0);
    chk("midrst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    chk("midrst_vec_addr", vec_addr, 32'h0);
    chk("midrst_int_ret", int_ret_pc, 32'h0);
    step(1);
    rst = 1;
    step(2);
    chk("midrst_reload", pc_q, 32'h100);
    step(2);
    chk("midrst_seq", pc_q, 32'h102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
